// File: rtl/apb_cot.sv
// apb_cot: free-running APB master driving a tan(n*pi/4) lookup slave
module apb_cot (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PWRITE_MASTER,
  input  logic [31:0] PADDR_MASTER,
  input  logic [31:0] PWDATA_MASTER,
  output logic [31:0] PRDATA_MASTER,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t      state_q, state_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, prdm_q, prdm_d;
  logic [31:0] ctrl_q, ctrl_d, out_q, out_d, fn;
  logic        wr_en;
  assign PSEL          = state_q != IDLE;
  assign PENABLE       = state_q == ACCESS;
  assign PWRITE        = pwrite_q;
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;
  assign PRDATA_MASTER = prdm_q;
  assign PREADY        = PSEL & PENABLE;
  assign PRDATA        = (PREADY && !PWRITE) ? (PADDR == 32'h0 ? ctrl_q : PADDR == 32'h4 ? out_q : 32'h0) : 32'h0;
  assign fn            = PWDATA[1] ? (PWDATA[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF) : {31'd0, PWDATA[0]};
  assign wr_en         = PREADY & PWRITE & (PADDR == 32'h0);
  // Master sequencing: a new request is captured whenever the FSM enters SETUP
  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    prdm_d   = prdm_q;
    case (state_q)
      IDLE:    state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = PREADY ? SETUP : ACCESS;
      default: state_d = IDLE;
    endcase
    if (state_d == SETUP) begin
      pwrite_d = PWRITE_MASTER;
      paddr_d  = PADDR_MASTER;
      pwdata_d = PWDATA_MASTER;
    end
    if (PREADY && !PWRITE) prdm_d = PRDATA;
  end
  // Slave registers: a write to control also refreshes the result
  always_comb begin
    ctrl_d = wr_en ? PWDATA : ctrl_q;
    out_d  = wr_en ? fn : out_q;
  end
  // State and register storage with asynchronous clear
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= 32'h0;
      pwdata_q <= 32'h0;
      prdm_q   <= 32'h0;
      ctrl_q   <= 32'h0;
      out_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      prdm_q   <= prdm_d;
      ctrl_q   <= ctrl_d;
      out_q    <= out_d;
    end
  end
endmodule

// File: tb/tb_apb_cot.sv
// tb_apb_cot: randomized self-checking bench for apb_cot against a register-level model
module tb_apb_cot;
  logic        PCLK = 1'b0, PRESET = 1'b0, PWRITE_MASTER = 1'b0;
  logic [31:0] PADDR_MASTER = 32'h0, PWDATA_MASTER = 32'h0;
  logic [31:0] PRDATA_MASTER, PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  int total = 0, bad = 0;
  logic [31:0] m_ctrl, m_out, m_prdm;
  logic [31:0] lut [4] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  bit          pend_v, pend_w;
  logic [31:0] pend_a, pend_d;

  apb_cot dut (
    .PCLK(PCLK), .PRESET(PRESET), .PWRITE_MASTER(PWRITE_MASTER), .PADDR_MASTER(PADDR_MASTER),
    .PWDATA_MASTER(PWDATA_MASTER), .PRDATA_MASTER(PRDATA_MASTER), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return a == 32'h0 ? m_ctrl : a == 32'h4 ? m_out : 32'h0;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_out = 0; m_prdm = 0; pend_v = 0;
  endtask

  // One full transfer: SETUP edge completes the previous transfer, then ACCESS
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    PWRITE_MASTER = w; PADDR_MASTER = a; PWDATA_MASTER = d;
    @(posedge PCLK); #1;
    if (pend_v) begin
      if (!pend_w) m_prdm = m_read(pend_a);
      else if (pend_a == 32'h0) begin m_ctrl = pend_d; m_out = lut[pend_d[1:0]]; end
    end
    total++;
    if (PRDATA_MASTER !== m_prdm) begin bad++; $display("FAIL prdata_master: got %h expected %h", PRDATA_MASTER, m_prdm); end
    total++;
    if ({PSEL, PENABLE} !== 2'b10) begin bad++; $display("FAIL setup_phase: got psel/penable %b expected 10", {PSEL, PENABLE}); end
    total++;
    if ({PWRITE, PADDR, PWDATA} !== {w, a, d}) begin bad++; $display("FAIL setup_bus: got %b %h %h expected %b %h %h", PWRITE, PADDR, PWDATA, w, a, d); end
    PWRITE_MASTER = 1'($urandom); PADDR_MASTER = $urandom; PWDATA_MASTER = $urandom;
    @(posedge PCLK); #1;
    total++;
    if ({PSEL, PENABLE, PREADY} !== 3'b111) begin bad++; $display("FAIL access_phase: got psel/penable/pready %b expected 111", {PSEL, PENABLE, PREADY}); end
    total++;
    if ({PWRITE, PADDR, PWDATA} !== {w, a, d}) begin bad++; $display("FAIL access_bus: got %b %h %h expected %b %h %h", PWRITE, PADDR, PWDATA, w, a, d); end
    exp_rd = w ? 32'h0 : m_read(a);
    total++;
    if (PRDATA !== exp_rd) begin bad++; $display("FAIL prdata: addr %h got %h expected %h", a, PRDATA, exp_rd); end
    pend_v = 1; pend_w = w; pend_a = a; pend_d = d;
  endtask

  task automatic test_reset();
    PRESET = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    model_reset();
    total++;
    if ({PSEL, PENABLE, PREADY, PWRITE} !== 4'b0 || PADDR !== 0 || PWDATA !== 0 || PRDATA !== 0 || PRDATA_MASTER !== 0) begin
      bad++; $display("FAIL reset_outputs: got sel%b en%b rdy%b wr%b addr%h wd%h rd%h rdm%h expected all 0", PSEL, PENABLE, PREADY, PWRITE, PADDR, PWDATA, PRDATA, PRDATA_MASTER);
    end
    @(negedge PCLK); PRESET = 1'b1; #1;
    total++;
    if (PSEL !== 1'b0) begin bad++; $display("FAIL idle_after_release: got psel %b expected 0", PSEL); end
  endtask

  task automatic test_writes();
    for (int n = 0; n < 6; n++) begin
      xfer(1'b1, 32'h0, n);
      xfer(1'b0, 32'h4, 32'h0);
    end
  endtask

  task automatic test_reads();
    xfer(1'b0, 32'h0, 32'h0);
    xfer(1'b0, 32'h4, 32'h0);
  endtask

  task automatic test_read_only();
    xfer(1'b1, 32'h4, 32'h1234_5678);
    xfer(1'b0, 32'h4, 32'h0);
    xfer(1'b0, 32'h8, 32'h0);
    xfer(1'b1, 32'h8, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_wide_n();
    xfer(1'b1, 32'h0, 32'hFFFF_FFFE);
    xfer(1'b0, 32'h4, 32'h0);
    xfer(1'b0, 32'h0, 32'h0);
    xfer(1'b1, 32'h0, 32'hFFFF_FFFE);
    xfer(1'b0, 32'h4, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = 32'h4;
        2: a = 32'h8;
        default: a = $urandom;
      endcase
      xfer(1'($urandom), a, $urandom);
    end
  endtask

  task automatic test_reset_mid();
    xfer(1'b1, 32'h0, 32'h1);
    xfer(1'b1, 32'h0, 32'h3);
    #2 PRESET = 1'b0;
    #1;
    model_reset();
    total++;
    if ({PSEL, PENABLE, PREADY, PWRITE} !== 4'b0 || PADDR !== 0 || PWDATA !== 0 || PRDATA !== 0 || PRDATA_MASTER !== 0) begin
      bad++; $display("FAIL mid_reset_outputs: got sel%b en%b rdy%b wr%b addr%h wd%h rd%h rdm%h expected all 0", PSEL, PENABLE, PREADY, PWRITE, PADDR, PWDATA, PRDATA, PRDATA_MASTER);
    end
    @(negedge PCLK); PRESET = 1'b1;
    xfer(1'b0, 32'h0, 32'h0);
    xfer(1'b0, 32'h4, 32'h0);
    xfer(1'b0, 32'h8, 32'h0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_writes();
    test_reads();
    test_read_only();
    test_wide_n();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
